bus_mem_responder: RTL
======================

# bus_mem_responder

Peripheral-side responder for the 8088 bus. It sits on the peripheral end of the processor pin bundle and decodes bus cycles from ALE, IOM, RD and WR against a configurable address window. It serves reads from and commits writes to an internal byte-wide memory array, driving the shared Data bus only while it is selected. An optional wait-state generator stretches cycles through READY.

## Interface
- BASE_ADDR, 20'h00000, base of the decoded window; low ADDR_BITS bits ignored.
- ADDR_BITS, 10, window and array size is 2**ADDR_BITS bytes; legal range 4..16.
- IS_IO, 0, respond when latched IOM == IS_IO (IOM=1 marks an I/O cycle).
- WAIT_STATES, 2, READY-low cycles per access when the wait-state feature is built in; legal range 0..15.
- CLK  input  1  bus clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- ALE  input  1  address latch enable, active-high.
- IOM  input  1  I/O-vs-memory qualifier, sampled with ALE.
- Address  input  20  demultiplexed bus address.
- RD  input  1  read strobe, active-low.
- WR  input  1  write strobe, active-low.
- Data  inout  8  shared data bus; high-Z unless driving a selected read.
- READY  output  1  1 = no wait requested.

## Operation
- FSM states: IDLE, ADDR, ACCESS, DONE, ERR.
- **IDLE:** ALE sampled high latches Address and IOM, then moves to ADDR.
  - sel = (Address[19:ADDR_BITS] == BASE_ADDR[19:ADDR_BITS]) && (IOM == IS_IO).
- **ADDR:**
  - If not sel: stay until ALE is seen again.
  - If RD low and WR high: go to ACCESS(read) and load rdata <= mem[addr[ADDR_BITS-1:0]].
  - If WR low and RD high: go to ACCESS(write).
  - If both low: go to ERR.
  - Every transition into ACCESS loads cnt <= WAIT_STATES.
- **ACCESS:**
  - cnt decrements each edge while nonzero.
  - Write: on the first edge with cnt==0, mem[addr] <= Data, then go to DONE. Exactly one commit per cycle.
  - Read: on the first edge with cnt==0, go to DONE.
- **DONE:** when RD and WR are both sampled high, go to IDLE.
- **ERR:** no memory access and Data high-Z. When RD and WR are both sampled high, go to IDLE.
- ALE sampled high in any state except IDLE aborts the current cycle. It relatches Address and IOM and goes to ADDR. An uncommitted write is dropped.
- Data enable = read cycle && state in {ACCESS, DONE} && RD low. The driven value is rdata.
- READY = 0 only when state == ACCESS and cnt != 0; otherwise 1.
- Memory contents are not cleared by reset.

## Timing
- Reset values: state IDLE, READY=1, Data high-Z, cnt=0, sel=0. Reset takes effect immediately and asynchronously, including mid-access; Data is released with no clock required.
- ALE latency: Address latched at edge E; decode is valid from E.
- Read: RD first sampled low at edge N.
  - Data is driven with the array value from just after N.
  - READY is low after N through edge N+W, with W = effective wait count.
  - DONE is reached at edge N+W+1.
  - Data is released combinationally once RD goes high.
- Write: WR first sampled low at edge N. Commit happens at edge N+W+1 using Data sampled at that edge.
- A write followed by a read of the same address returns the new value (no bypass hazard; the commit precedes any later ADDR state).
- Unselected cycles: READY stays 1 and Data stays high-Z throughout.

## Configuration
- WAIT_STATE_EN defined: effective W = WAIT_STATES, and READY behaves as above.
- WAIT_STATE_EN undefined: effective W = 0, READY is tied to 1, and cnt logic is removed. The WAIT_STATES parameter is ignored.

## Test plan
- **Reset:** assert RESET=0 mid-read while Data is driving.
  - Data goes high-Z and READY=1 immediately.
  - After release the state is IDLE and mem[0x005] still holds its previous value.
- **Write then read, WAIT_STATE_EN, WAIT_STATES=2:** ALE with Address=20'h00005, IOM=0, then WR low with Data=8'hA5.
  - READY low for exactly 2 edges and one commit.
  - The next read of 20'h00005 drives 8'hA5, with READY low for 2 edges.
- **No wait states (macro undefined):** write 8'h3C to 20'h003FF, then read it back.
  - READY constant 1 and readback 8'h3C.
- **Out-of-window:** BASE_ADDR=20'h00000, ADDR_BITS=10, read 20'h00400 or read 20'h00005 with IOM=1.
  - Data high-Z, READY 1, memory unchanged.
- **Conflict:** RD and WR both low after ALE with Address=20'h00010.
  - Go to ERR, no write to 0x010, Data high-Z, return to IDLE once both strobes are high.
- **Abort:** WAIT_STATES=3, WR low for 1 cycle, then ALE with new Address=20'h00020 before the commit.
  - The old address is unchanged.
  - The next cycle's access to 0x020 proceeds normally.

Source files
------------

// File: rtl/bus_mem_responder_if.sv
// bus_mem_responder_if: 8088 bus control/address pins seen by a peripheral.
// The shared Data bus is kept as a plain inout port on the responder.
interface bus_mem_responder_if;
  logic        ALE;
  logic        IOM;
  logic [19:0] Address;
  logic        RD;
  logic        WR;
  logic        READY;

  modport master (
    output ALE, IOM, Address, RD, WR,
    input  READY
  );

  modport slave (
    input  ALE, IOM, Address, RD, WR,
    output READY
  );
endinterface

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: 8088 peripheral responder backed by a byte array.
// Define WAIT_STATE_EN to build in the READY wait-state generator.
module bus_mem_responder #(
  parameter logic [19:0] BASE_ADDR   = 20'h00000,
  parameter int          ADDR_BITS   = 10,
  parameter bit          IS_IO       = 1'b0,
  parameter int          WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  bus_mem_responder_if.slave bus,
  inout  wire  [7:0]        Data
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACCESS, DONE, ERR
  } state_t;

  state_t state, state_d;

  logic [ADDR_BITS-1:0] addr_q;
  logic                 sel_q;
  logic                 is_rd_q;
  logic [7:0]           rdata;
  logic                 sel_d;
  logic                 go_rd;
  logic                 go_wr;
  logic                 commit;
  logic                 cnt_zero;
  logic [7:0]           mem [2**ADDR_BITS];

  assign sel_d =
    (bus.Address[19:ADDR_BITS] == BASE_ADDR[19:ADDR_BITS]) &&
    (bus.IOM == IS_IO);

  // ALE outranks everything outside IDLE: a late ALE drops the cycle.
  always_comb begin
    state_d = state;
    go_rd   = 1'b0;
    go_wr   = 1'b0;
    commit  = 1'b0;
    if (bus.ALE) begin
      state_d = ADDR;
    end else begin
      unique case (state)
        IDLE: state_d = IDLE;
        ADDR: begin
          if (sel_q) begin
            unique case ({bus.RD, bus.WR})
              2'b01: begin
                go_rd   = 1'b1;
                state_d = ACCESS;
              end
              2'b10: begin
                go_wr   = 1'b1;
                state_d = ACCESS;
              end
              2'b00:   state_d = ERR;
              default: state_d = ADDR;
            endcase
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            commit  = !is_rd_q;
            state_d = DONE;
          end
        end
        DONE, ERR: begin
          if (bus.RD && bus.WR) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      addr_q  <= '0;
      sel_q   <= 1'b0;
      is_rd_q <= 1'b0;
      rdata   <= 8'h00;
    end else begin
      state <= state_d;
      if (bus.ALE) begin
        addr_q <= bus.Address[ADDR_BITS-1:0];
        sel_q  <= sel_d;
      end
      if (go_rd || go_wr) is_rd_q <= go_rd;
      if (go_rd) rdata <= mem[addr_q];
    end
  end

  always_ff @(posedge CLK) begin
    if (commit) mem[addr_q] <= Data;
  end

`ifdef WAIT_STATE_EN
  logic [3:0] cnt;

  assign cnt_zero  = (cnt == 4'd0);
  assign bus.READY = !((state == ACCESS) && !cnt_zero);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt <= 4'd0;
    end else if (go_rd || go_wr) begin
      cnt <= WAIT_STATES[3:0];
    end else if (state == ACCESS && !cnt_zero) begin
      cnt <= cnt - 4'd1;
    end
  end
`else
  assign cnt_zero  = 1'b1;
  assign bus.READY = 1'b1;
`endif

  assign Data =
    (is_rd_q && !bus.RD &&
     (state == ACCESS || state == DONE)) ? rdata : 8'hzz;

endmodule
